pc_npc_sequencer: RTL and testbench

PC_NPC_SEQUENCER -- requirements
Module: pc_npc_sequencer

---
 rtl/pc_npc_sequencer.sv | 89 ++++++++
 tb/tb_pc_npc_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pc_npc_sequencer.sv
// SPARC fetch-address sequencer: produces the PC/nPC pair, the delay-slot annul flag,
// and a one-cycle misaligned-target pulse for the PC pipeline register.
module pc_npc_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        branch_taken,
  input  logic        branch_always,
  input  logic        annul_req,
  input  logic [31:0] branch_target,
  input  logic        trap_req,
  input  logic [31:0] trap_vector,
  output logic [31:0] PC_out,
  output logic [31:0] nPC_out,
  output logic        annul_out,
  output logic        valid_out,
  output logic        align_err
);

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, ANNUL = 2'd2} state_t;

  state_t      r_state;
  logic [31:0] r_pc, r_npc;
  logic        r_annul, r_valid, r_align;

  logic [31:0] w_npc_seq, w_trap_pc, w_br_tgt;
  logic        w_ba_annul;

  assign w_npc_seq  = r_npc + 32'd4;
  assign w_trap_pc  = {trap_vector[31:2], 2'b00};
  assign w_br_tgt   = {branch_target[31:2], 2'b00};
  assign w_ba_annul = annul_req & branch_always;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= BOOT;
      r_pc    <= 32'h0000_0000;
      r_npc   <= 32'h0000_0004;
      r_annul <= 1'b0;
      r_valid <= 1'b0;
      r_align <= 1'b0;
    end else if (!enable) begin
      r_align <= 1'b0;
    end else begin
      r_align <= 1'b0;
      case (r_state)
        BOOT: begin
          r_state <= RUN;
          r_valid <= 1'b1;
        end
        RUN: begin
          if (trap_req) begin
            r_pc    <= w_trap_pc;
            r_npc   <= w_trap_pc + 32'd4;
            r_annul <= 1'b0;
            r_align <= |trap_vector[1:0];
            r_state <= RUN;
          end else if (branch_taken) begin
            r_pc    <= r_npc;
            r_npc   <= w_br_tgt;
            r_annul <= w_ba_annul;
            r_align <= |branch_target[1:0];
            r_state <= w_ba_annul ? ANNUL : RUN;
          end else begin
            r_pc    <= r_npc;
            r_npc   <= w_npc_seq;
            r_annul <= annul_req;
            r_state <= annul_req ? ANNUL : RUN;
          end
        end
        ANNUL: begin
          // squashed delay slot: control inputs are not acted on
          r_pc    <= r_npc;
          r_npc   <= w_npc_seq;
          r_annul <= 1'b0;
          r_state <= RUN;
        end
        default: r_state <= BOOT;
      endcase
    end
  end

  assign PC_out    = r_pc;
  assign nPC_out   = r_npc;
  assign annul_out = r_annul;
  assign valid_out = r_valid;
  assign align_err = r_align;

endmodule

// File: tb/tb_pc_npc_sequencer.sv
// Self-checking bench: directed vector table for the scenario corners, then random
// stimulus against an instruction-level PC/nPC reference model.
module tb_pc_npc_sequencer;

  logic        clk = 1'b0;
  logic        reset, enable, branch_taken, branch_always, annul_req, trap_req;
  logic [31:0] branch_target, trap_vector;
  logic [31:0] PC_out, nPC_out;
  logic        annul_out, valid_out, align_err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_npc_sequencer dut (
    .clk(clk), .reset(reset), .enable(enable),
    .branch_taken(branch_taken), .branch_always(branch_always), .annul_req(annul_req),
    .branch_target(branch_target), .trap_req(trap_req), .trap_vector(trap_vector),
    .PC_out(PC_out), .nPC_out(nPC_out), .annul_out(annul_out),
    .valid_out(valid_out), .align_err(align_err)
  );

  typedef struct {
    bit          rst, en, bt, ba, ar, tr;
    logic [31:0] tgt, tv;
    logic [31:0] epc, enpc;
    bit          ean, ev, eal;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit rst, bit en, bit bt, bit ba, bit ar, bit tr,
                             logic [31:0] tgt, logic [31:0] tv,
                             logic [31:0] epc, logic [31:0] enpc, bit ean, bit ev, bit eal);
    vec_t r;
    r.rst = rst; r.en = en; r.bt = bt; r.ba = ba; r.ar = ar; r.tr = tr;
    r.tgt = tgt; r.tv = tv; r.epc = epc; r.enpc = enpc;
    r.ean = ean; r.ev = ev; r.eal = eal;
    return r;
  endfunction

  task automatic drive(bit rst, bit en, bit bt, bit ba, bit ar, bit tr,
                       logic [31:0] tgt, logic [31:0] tv);
    reset = ~rst; enable = en; branch_taken = bt; branch_always = ba;
    annul_req = ar; trap_req = tr; branch_target = tgt; trap_vector = tv;
  endtask

  task automatic check(string name, int idx, logic [31:0] epc, logic [31:0] enpc,
                       bit ean, bit ev, bit eal);
    n_vec++;
    if (PC_out !== epc || nPC_out !== enpc || annul_out !== ean ||
        valid_out !== ev || align_err !== eal) begin
      n_bad++;
      $display("FAIL %s[%0d]: got pc=%h npc=%h an=%b v=%b al=%b, want pc=%h npc=%h an=%b v=%b al=%b",
               name, idx, PC_out, nPC_out, annul_out, valid_out, align_err,
               epc, enpc, ean, ev, eal);
    end
  endtask

  // reference model state: annulled slot pending == annul_out, boot pending == !booted
  logic [31:0] m_pc, m_npc;
  bit          m_an, m_v, m_al, m_booted;

  task automatic model_step(bit rst, bit en, bit bt, bit ba, bit ar, bit tr,
                            logic [31:0] tgt, logic [31:0] tv);
    if (rst) begin
      m_pc = 0; m_npc = 4; m_an = 0; m_v = 0; m_al = 0; m_booted = 0;
    end else if (!en) begin
      m_al = 0;
    end else if (!m_booted) begin
      m_booted = 1; m_v = 1; m_al = 0;
    end else if (m_an) begin
      m_pc = m_npc; m_npc = m_npc + 4; m_an = 0; m_al = 0;
    end else if (tr) begin
      m_pc = tv & 32'hFFFF_FFFC; m_npc = m_pc + 4; m_an = 0; m_al = (tv % 4) != 0;
    end else if (bt) begin
      m_pc = m_npc; m_npc = tgt & 32'hFFFF_FFFC; m_an = ar && ba; m_al = (tgt % 4) != 0;
    end else begin
      m_pc = m_npc; m_npc = m_npc + 4; m_an = ar; m_al = 0;
    end
  endtask

  initial begin
    //            rst en bt ba ar tr tgt            tv          pc            npc           an v al
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,      32'h0,        32'h4,        0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,      32'h0,        32'h4,        0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,      32'h4,        32'h8,        0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,      32'h8,        32'hC,        0, 1, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 32'h100,      32'h0,      32'hC,        32'h100,      0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,      32'h100,      32'h104,      0, 1, 0));
    tbl.push_back(v(1, 1, 1, 0, 0, 1, 32'h0,        32'h0,      32'h0,        32'h4,        0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,      32'h0,        32'h4,        0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,      32'h4,        32'h8,        0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,      32'h8,        32'hC,        0, 1, 0));
    tbl.push_back(v(0, 1, 1, 1, 1, 0, 32'h40,       32'h0,      32'hC,        32'h40,       1, 1, 0));
    tbl.push_back(v(0, 1, 1, 0, 1, 1, 32'h999,      32'h777,    32'h40,       32'h44,       0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 1, 0, 32'h0,        32'h0,      32'h44,       32'h48,       1, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,      32'h48,       32'h4C,       0, 1, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h500,      32'h203,    32'h200,      32'h204,      0, 1, 1));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,      32'h204,      32'h208,      0, 1, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 32'h10,       32'h0,      32'h208,      32'h10,       0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 1, 0, 32'h0,        32'h0,      32'h10,       32'h14,       1, 1, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 1, 32'h80,       32'h90,     32'h10,       32'h14,       1, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 32'h0,        32'h0,      32'h10,       32'h14,       1, 1, 0));
    tbl.push_back(v(0, 0, 1, 1, 1, 1, 32'h81,       32'h93,     32'h10,       32'h14,       1, 1, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 1, 32'h0,        32'h300,    32'h0,        32'h4,        0, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h80,       32'h300,    32'h0,        32'h4,        0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,      32'h4,        32'h8,        0, 1, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 32'hFFFFFFFC, 32'h0,      32'h8,        32'hFFFFFFFC, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,      32'hFFFFFFFC, 32'h0,        0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,      32'h0,        32'h4,        0, 1, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 32'h1001,     32'h0,      32'h4,        32'h1000,     0, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,      32'h4,        32'h1000,     0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,      32'h1000,     32'h1004,     0, 1, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 32'h2000,     32'h0,      32'h1004,     32'h2000,     0, 1, 0));
    tbl.push_back(v(0, 1, 1, 0, 1, 0, 32'h3002,     32'h0,      32'h2000,     32'h3000,     0, 1, 1));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,      32'h3000,     32'h3004,     0, 1, 0));

    drive(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].bt, tbl[i].ba, tbl[i].ar, tbl[i].tr, tbl[i].tgt, tbl[i].tv);
      @(posedge clk); #1;
      check("dir", i, tbl[i].epc, tbl[i].enpc, tbl[i].ean, tbl[i].ev, tbl[i].eal);
    end

    // randomized run, starting from a reset edge so the model is synchronised
    model_step(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    drive(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    @(posedge clk); #1;
    check("rnd_rst", 0, m_pc, m_npc, m_an, m_v, m_al);
    for (int i = 0; i < 600; i++) begin
      bit          rst, en, bt, ba, ar, tr;
      logic [31:0] tgt, tv;
      rst = ($urandom_range(0, 39) == 0);
      en  = ($urandom_range(0, 4) != 0);
      bt  = ($urandom_range(0, 2) == 0);
      ba  = $urandom_range(0, 1) != 0;
      ar  = ($urandom_range(0, 3) == 0);
      tr  = ($urandom_range(0, 9) == 0);
      tgt = $urandom();
      tv  = $urandom();
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) tv[1:0]  = 2'b00;
      if ($urandom_range(0, 15) == 0) tgt = 32'hFFFFFFFC;
      drive(rst, en, bt, ba, ar, tr, tgt, tv);
      model_step(rst, en, bt, ba, ar, tr, tgt, tv);
      @(posedge clk); #1;
      check("rnd", i, m_pc, m_npc, m_an, m_v, m_al);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
